// File: rtl/reg8_dump_reader.sv
// Snapshot NREG 8-bit registers on start and stream them out over valid/ready, index 0 first.
// Optional REG8_DUMP_CHECKSUM_EN appends a two's-complement checksum byte to each dump.
module reg8_dump_reader #(
  parameter int NREG = 4,
  parameter int IDXW = 4
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              start,
  input  logic [8*NREG-1:0] regs_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

`ifdef REG8_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t                 state, state_n;
  logic [IDXW-1:0]        idx, idx_n, idx_inc;
  logic [NREG-1:0][7:0]   snap, snap_n;
  logic [7:0]             data_n, nxt_byte;
  logic                   valid_n, busy_n, done_n;
  logic                   xfer;
`ifdef REG8_DUMP_CHECKSUM_EN
  logic [7:0]             sum, sum_n, sum_add;
`endif

  assign xfer    = out_valid & out_ready;
  assign idx_inc = idx + IDXW'(1);

  always_comb begin
    nxt_byte = 8'h00;
    for (int k = 0; k < NREG; k++)
      if (idx_inc == IDXW'(k)) nxt_byte = snap[k];
  end

`ifdef REG8_DUMP_CHECKSUM_EN
  assign sum_add = sum + out_data;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    snap_n  = snap;
    data_n  = out_data;
    valid_n = out_valid;
    busy_n  = busy;
    done_n  = 1'b0;
`ifdef REG8_DUMP_CHECKSUM_EN
    sum_n   = sum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          snap_n  = regs_in;
          idx_n   = '0;
          data_n  = regs_in[7:0];
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = SEND;
`ifdef REG8_DUMP_CHECKSUM_EN
          sum_n   = 8'h00;
`endif
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef REG8_DUMP_CHECKSUM_EN
          sum_n = sum_add;
`endif
          if (idx == IDXW'(NREG-1)) begin
`ifdef REG8_DUMP_CHECKSUM_EN
            // Negated sum makes all NREG+1 bytes add to zero mod 256.
            data_n  = (~sum_add) + 8'h01;
            state_n = CSUM;
`else
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
`endif
          end else begin
            idx_n  = idx_inc;
            data_n = nxt_byte;
          end
        end
      end
`ifdef REG8_DUMP_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state     <= IDLE;
      idx       <= '0;
      snap      <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REG8_DUMP_CHECKSUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      snap      <= snap_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef REG8_DUMP_CHECKSUM_EN
      sum       <= sum_n;
`endif
    end
  end

endmodule

// File: tb/tb_reg8_dump_reader.sv
// Directed, table-driven bench for reg8_dump_reader (NREG=4), plus a hand-written async reset sequence.
module tb_reg8_dump_reader;

  localparam logic [31:0] R1 = 32'h44332211;
  localparam logic [31:0] R2 = 32'hDDCCBBAA;

  logic        clock = 1'b0;
  logic        reset_N = 1'b0;
  logic        start = 1'b0;
  logic [31:0] regs_in = R1;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  reg8_dump_reader #(.NREG(4), .IDXW(4)) dut (
    .clock(clock), .reset_N(reset_N), .start(start), .regs_in(regs_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Inputs held across the edge, outputs expected just after it.
  typedef struct {
    logic        st;
    logic        rdy;
    logic [31:0] regs;
    logic        v;
    logic [7:0]  d;
    logic        b;
    logic        dn;
    logic        chkd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic st, logic rdy, logic [31:0] regs,
                              logic v, logic [7:0] d, logic b, logic dn, logic chkd);
    vec_t r;
    r.st = st; r.rdy = rdy; r.regs = regs; r.v = v; r.d = d; r.b = b; r.dn = dn; r.chkd = chkd;
    tbl.push_back(r);
  endfunction

  // Last-byte transfer: optional checksum byte, then the done cycle.
  function automatic void end_rows(logic [7:0] cs, logic [31:0] regs);
`ifdef REG8_DUMP_CHECKSUM_EN
    add(0, 1, regs, 1, cs, 1, 0, 1);
`else
    if (cs == 8'hxx) add(0, 1, regs, 0, 8'h00, 0, 0, 0);
`endif
    add(0, 1, regs, 0, 8'h00, 0, 1, 0);
  endfunction

  function automatic void idle_row(logic [31:0] regs);
    add(0, 1, regs, 0, 8'h00, 0, 0, 0);
  endfunction

  task automatic check1(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // basic dump, ready tied high
    add(1, 1, R1, 1, 8'h11, 1, 0, 1);
    add(0, 1, R1, 1, 8'h22, 1, 0, 1);
    add(0, 1, R1, 1, 8'h33, 1, 0, 1);
    add(0, 1, R1, 1, 8'h44, 1, 0, 1);
    end_rows(8'h56, R1);
    idle_row(R1);
    // back-pressure for 3 cycles on byte 22
    add(1, 1, R1, 1, 8'h11, 1, 0, 1);
    add(0, 1, R1, 1, 8'h22, 1, 0, 1);
    add(0, 0, R1, 1, 8'h22, 1, 0, 1);
    add(0, 0, R1, 1, 8'h22, 1, 0, 1);
    add(0, 0, R1, 1, 8'h22, 1, 0, 1);
    add(0, 1, R1, 1, 8'h33, 1, 0, 1);
    add(0, 1, R1, 1, 8'h44, 1, 0, 1);
    end_rows(8'h56, R1);
    idle_row(R1);
    // start pulses mid-dump are ignored
    add(1, 1, R1, 1, 8'h11, 1, 0, 1);
    add(0, 1, R1, 1, 8'h22, 1, 0, 1);
    add(1, 1, R1, 1, 8'h33, 1, 0, 1);
    add(1, 1, R1, 1, 8'h44, 1, 0, 1);
    end_rows(8'h56, R1);
    idle_row(R1);
    // regs change after snapshot; restart in the done cycle picks up new bank
    add(1, 1, R1, 1, 8'h11, 1, 0, 1);
    add(0, 1, R2, 1, 8'h22, 1, 0, 1);
    add(0, 1, R2, 1, 8'h33, 1, 0, 1);
    add(0, 1, R2, 1, 8'h44, 1, 0, 1);
    end_rows(8'h56, R2);
    add(1, 1, R2, 1, 8'hAA, 1, 0, 1);
    add(0, 1, R2, 1, 8'hBB, 1, 0, 1);
    add(0, 1, R2, 1, 8'hCC, 1, 0, 1);
    add(0, 1, R2, 1, 8'hDD, 1, 0, 1);
    end_rows(8'hF2, R2);
    idle_row(R2);

    // reset state
    #2;
    check1("rst_valid", {7'd0, out_valid}, 8'h00);
    check1("rst_busy",  {7'd0, busy},      8'h00);
    check1("rst_done",  {7'd0, done},      8'h00);
    check1("rst_data",  out_data,          8'h00);
    repeat (2) @(posedge clock);
    #3 reset_N = 1'b1;
    @(posedge clock); #1;
    check1("idle_valid", {7'd0, out_valid}, 8'h00);

    foreach (tbl[i]) begin
      start     = tbl[i].st;
      out_ready = tbl[i].rdy;
      regs_in   = tbl[i].regs;
      @(posedge clock); #1;
      check1($sformatf("row%0d_valid", i), {7'd0, out_valid}, {7'd0, tbl[i].v});
      check1($sformatf("row%0d_busy", i),  {7'd0, busy},      {7'd0, tbl[i].b});
      check1($sformatf("row%0d_done", i),  {7'd0, done},      {7'd0, tbl[i].dn});
      if (tbl[i].chkd) check1($sformatf("row%0d_data", i), out_data, tbl[i].d);
    end

    // async reset in the middle of a dump while 33 is presented
    start = 1'b1; out_ready = 1'b1; regs_in = R1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check1("pre_rst_data", out_data, 8'h33);
    #2 reset_N = 1'b0;
    #1;
    check1("arst_valid", {7'd0, out_valid}, 8'h00);
    check1("arst_busy",  {7'd0, busy},      8'h00);
    check1("arst_done",  {7'd0, done},      8'h00);
    check1("arst_data",  out_data,          8'h00);
    @(posedge clock); #3 reset_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      check1("post_rst_valid", {7'd0, out_valid}, 8'h00);
      check1("post_rst_done",  {7'd0, done},      8'h00);
    end
    // fresh dump after reset starts at byte 0
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check1("post_rst_first", out_data, 8'h11);
    check1("post_rst_busy", {7'd0, busy}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
